nios_mult_pipe: RTL and testbench

NIOS_MULT_PIPE -- requirements
Module: nios_mult_pipe

---
 rtl/nios_mult_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_nios_mult_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/nios_mult_pipe.sv
// Three-stage pipelined DATA_W x DATA_W multiplier with low/high product selection,
// valid/ready handshakes, backpressure stall and flush.
module nios_mult_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);
    localparam int HALF_W = DATA_W / 2;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        MODE_MUL    = 2'd0,
        MODE_MULXSS = 2'd1,
        MODE_MULXSU = 2'd2,
        MODE_MULXUU = 2'd3
    } mode_e;

    logic stall_s, accept_s;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_src1_q, s1_src1_d, s1_src2_q, s1_src2_d;
    mode_e             s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_ll_q, s2_ll_d, s2_lh_q, s2_lh_d;
    logic [DATA_W-1:0] s2_hl_q, s2_hl_d, s2_hh_q, s2_hh_d;
    logic [DATA_W-1:0] s2_corr_q, s2_corr_d;
    mode_e             s2_mode_q, s2_mode_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

    logic              s3_valid_q, s3_valid_d;
    logic [DATA_W-1:0] s3_result_q, s3_result_d;
    logic [TAG_W-1:0]  s3_tag_q, s3_tag_d;

    logic [DATA_W-1:0] pp_ll_s, pp_lh_s, pp_hl_s, pp_hh_s, corr_s;
    logic [PROD_W-1:0] sum_s;
    logic [DATA_W-1:0] hi_s, sel_s;

    assign stall_s    = s3_valid_q && !out_ready;
    assign in_ready   = !stall_s && !flush;
    assign accept_s   = in_valid && in_ready;
    assign out_valid  = s3_valid_q;
    assign out_result = s3_result_q;
    assign out_tag    = s3_tag_q;

    // Stage 1 next state: capture the request whenever the pipe moves.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_src1_d  = s1_src1_q;
        s1_src2_d  = s1_src2_q;
        s1_mode_d  = s1_mode_q;
        s1_tag_d   = s1_tag_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (!stall_s) begin
            s1_valid_d = accept_s;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (!stall_s) begin
            s1_src1_d = in_src1;
            s1_src2_d = in_src2;
            s1_mode_d = mode_e'(in_mode);
            s1_tag_d  = in_tag;
        end else begin
            s1_src1_d = s1_src1_q;
        end
    end

    // Unsigned half-width partial products; signed operands are fixed up in the
    // high half by subtracting the other operand (two's-complement weight -2^DATA_W).
    always_comb begin
        pp_ll_s = DATA_W'(s1_src1_q[HALF_W-1:0])      * DATA_W'(s1_src2_q[HALF_W-1:0]);
        pp_lh_s = DATA_W'(s1_src1_q[HALF_W-1:0])      * DATA_W'(s1_src2_q[DATA_W-1:HALF_W]);
        pp_hl_s = DATA_W'(s1_src1_q[DATA_W-1:HALF_W]) * DATA_W'(s1_src2_q[HALF_W-1:0]);
        pp_hh_s = DATA_W'(s1_src1_q[DATA_W-1:HALF_W]) * DATA_W'(s1_src2_q[DATA_W-1:HALF_W]);
        corr_s  = {DATA_W{1'b0}};
        case (s1_mode_q)
            MODE_MULXSS: corr_s = (s1_src1_q[DATA_W-1] ? s1_src2_q : {DATA_W{1'b0}})
                                + (s1_src2_q[DATA_W-1] ? s1_src1_q : {DATA_W{1'b0}});
            MODE_MULXSU: corr_s = s1_src1_q[DATA_W-1] ? s1_src2_q : {DATA_W{1'b0}};
            MODE_MUL:    corr_s = {DATA_W{1'b0}};
            MODE_MULXUU: corr_s = {DATA_W{1'b0}};
            default:     corr_s = {DATA_W{1'b0}};
        endcase
    end

    // Stage 2 next state.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_ll_d    = s2_ll_q;
        s2_lh_d    = s2_lh_q;
        s2_hl_d    = s2_hl_q;
        s2_hh_d    = s2_hh_q;
        s2_corr_d  = s2_corr_q;
        s2_mode_d  = s2_mode_q;
        s2_tag_d   = s2_tag_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (!stall_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (!stall_s) begin
            s2_ll_d   = pp_ll_s;
            s2_lh_d   = pp_lh_s;
            s2_hl_d   = pp_hl_s;
            s2_hh_d   = pp_hh_s;
            s2_corr_d = corr_s;
            s2_mode_d = s1_mode_q;
            s2_tag_d  = s1_tag_q;
        end else begin
            s2_ll_d = s2_ll_q;
        end
    end

    // Sum partial products and pick the product half.
    always_comb begin
        sum_s = {s2_hh_q, s2_ll_q}
              + {{HALF_W{1'b0}}, s2_lh_q, {HALF_W{1'b0}}}
              + {{HALF_W{1'b0}}, s2_hl_q, {HALF_W{1'b0}}};
        hi_s  = sum_s[PROD_W-1:DATA_W] - s2_corr_q;
        case (s2_mode_q)
            MODE_MUL:    sel_s = sum_s[DATA_W-1:0];
            MODE_MULXSS: sel_s = hi_s;
            MODE_MULXSU: sel_s = hi_s;
            MODE_MULXUU: sel_s = hi_s;
            default:     sel_s = hi_s;
        endcase
    end

    // Stage 3 next state.
    always_comb begin
        s3_valid_d  = s3_valid_q;
        s3_result_d = s3_result_q;
        s3_tag_d    = s3_tag_q;
        if (flush) begin
            s3_valid_d = 1'b0;
        end else if (!stall_s) begin
            s3_valid_d = s2_valid_q;
        end else begin
            s3_valid_d = s3_valid_q;
        end
        if (!stall_s) begin
            s3_result_d = sel_s;
            s3_tag_d    = s2_tag_q;
        end else begin
            s3_result_d = s3_result_q;
        end
    end

    // Pipeline registers; reset has priority over flush and stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_src1_q   <= {DATA_W{1'b0}};
            s1_src2_q   <= {DATA_W{1'b0}};
            s1_mode_q   <= MODE_MUL;
            s1_tag_q    <= {TAG_W{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_ll_q     <= {DATA_W{1'b0}};
            s2_lh_q     <= {DATA_W{1'b0}};
            s2_hl_q     <= {DATA_W{1'b0}};
            s2_hh_q     <= {DATA_W{1'b0}};
            s2_corr_q   <= {DATA_W{1'b0}};
            s2_mode_q   <= MODE_MUL;
            s2_tag_q    <= {TAG_W{1'b0}};
            s3_valid_q  <= 1'b0;
            s3_result_q <= {DATA_W{1'b0}};
            s3_tag_q    <= {TAG_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_src1_q   <= s1_src1_d;
            s1_src2_q   <= s1_src2_d;
            s1_mode_q   <= s1_mode_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_ll_q     <= s2_ll_d;
            s2_lh_q     <= s2_lh_d;
            s2_hl_q     <= s2_hl_d;
            s2_hh_q     <= s2_hh_d;
            s2_corr_q   <= s2_corr_d;
            s2_mode_q   <= s2_mode_d;
            s2_tag_q    <= s2_tag_d;
            s3_valid_q  <= s3_valid_d;
            s3_result_q <= s3_result_d;
            s3_tag_q    <= s3_tag_d;
        end
    end
endmodule

// File: tb/tb_nios_mult_pipe.sv
// Directed bench for nios_mult_pipe: vector table plus backpressure, flush and reset sequences.
module tb_nios_mult_pipe;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int N_VEC  = 16;

    logic              clk = 1'b0;
    logic              reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [DATA_W-1:0] in_src1, in_src2, out_result;
    logic [1:0]        in_mode;
    logic [TAG_W-1:0]  in_tag, out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        vld;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [1:0]  mode;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [N_VEC];

    nios_mult_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_mode(in_mode), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge and drive a request.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] m, input logic [4:0] t);
        @(posedge clk);
        #1;
        in_valid = v;
        in_src1  = a;
        in_src2  = b;
        in_mode  = m;
        in_tag   = t;
    endtask

    task automatic chk_out(input string name, input logic [31:0] res, input logic [4:0] tag);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_result"}, 64'(out_result), 64'(res));
        chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 5'd1,  32'h00000001};
        tbl[1]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd1, 5'd2,  32'h00000000};
        tbl[2]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd2, 5'd3,  32'hFFFFFFFF};
        tbl[3]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, 5'd4,  32'hFFFFFFFE};
        tbl[4]  = '{1'b1, 32'h00010000, 32'h00010000, 2'd0, 5'd5,  32'h00000000};
        tbl[5]  = '{1'b1, 32'h00010000, 32'h00010000, 2'd3, 5'd6,  32'h00000001};
        tbl[6]  = '{1'b1, 32'h80000000, 32'h80000000, 2'd1, 5'd7,  32'h40000000};
        tbl[7]  = '{1'b1, 32'h80000000, 32'h80000000, 2'd3, 5'd8,  32'h40000000};
        tbl[8]  = '{1'b0, 32'h00000007, 32'h00000006, 2'd0, 5'd9,  32'h00000000};
        tbl[9]  = '{1'b1, 32'hFFFFFFFE, 32'h00000003, 2'd1, 5'd10, 32'hFFFFFFFF};
        tbl[10] = '{1'b1, 32'hFFFFFFFE, 32'h80000000, 2'd2, 5'd11, 32'hFFFFFFFF};
        tbl[11] = '{1'b1, 32'h12345678, 32'h00000010, 2'd3, 5'd12, 32'h00000001};
        tbl[12] = '{1'b1, 32'h12345678, 32'h00000010, 2'd0, 5'd13, 32'h23456780};
        tbl[13] = '{1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 2'd2, 5'd14, 32'h7FFFFFFE};
        tbl[14] = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'd1, 5'd15, 32'h3FFFFFFF};
        tbl[15] = '{1'b1, 32'h00000007, 32'h00000006, 2'd0, 5'd16, 32'h0000002A};

        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_src1 = 32'd0; in_src2 = 32'd0; in_mode = 2'd0; in_tag = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);

        // Back-to-back table; output in cycle c belongs to the request of cycle c-3.
        for (int c = 0; c < N_VEC + 3; c++) begin
            if (c < N_VEC) drive(tbl[c].vld, tbl[c].s1, tbl[c].s2, tbl[c].mode, tbl[c].tag);
            else           drive(1'b0, 32'd0, 32'd0, 2'd0, 5'd0);
            @(negedge clk);
            chk($sformatf("tbl_c%0d_in_ready", c), 64'(in_ready), 64'd1);
            if (c >= 3 && tbl[c-3].vld) begin
                chk_out($sformatf("tbl%0d", c - 3), tbl[c-3].exp, tbl[c-3].tag);
            end else begin
                chk($sformatf("tbl_c%0d_bubble", c), 64'(out_valid), 64'd0);
            end
        end

        // Backpressure: three in flight, then five stalled cycles with a pending request.
        drive(1'b1, 32'd3, 32'd5, 2'd0, 5'd20);
        drive(1'b1, 32'hFFFFFFFF, 32'd2, 2'd3, 5'd21);
        drive(1'b1, 32'hFFFFFFFF, 32'd2, 2'd1, 5'd22);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 32'd9, 32'd9, 2'd0, 5'd23);
            out_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("bp_stall%0d_in_ready", c), 64'(in_ready), 64'd0);
            chk_out($sformatf("bp_stall%0d", c), 32'd15, 5'd20);
        end
        drive(1'b0, 32'd0, 32'd0, 2'd0, 5'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk_out("bp_drain0", 32'd15, 5'd20);
        drive(1'b0, 32'd0, 32'd0, 2'd0, 5'd0);
        @(negedge clk);
        chk_out("bp_drain1", 32'h00000001, 5'd21);
        drive(1'b0, 32'd0, 32'd0, 2'd0, 5'd0);
        @(negedge clk);
        chk_out("bp_drain2", 32'hFFFFFFFF, 5'd22);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 32'd0, 32'd0, 2'd0, 5'd0);
            @(negedge clk);
            chk($sformatf("bp_empty%0d_valid", c), 64'(out_valid), 64'd0);
        end

        // Flush one cycle after two acceptances, with a request in the flush cycle.
        drive(1'b1, 32'd2, 32'd3, 2'd0, 5'd24);
        drive(1'b1, 32'd4, 32'd5, 2'd0, 5'd25);
        drive(1'b1, 32'd6, 32'd7, 2'd0, 5'd26);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 32'd0, 32'd0, 2'd0, 5'd0);
            flush = 1'b0;
            @(negedge clk);
            chk($sformatf("fl_after%0d_valid", c), 64'(out_valid), 64'd0);
        end
        chk("fl_in_ready_after", 64'(in_ready), 64'd1);

        // Reset with three operations in flight while the consumer is stalled.
        out_ready = 1'b0;
        drive(1'b1, 32'd10, 32'd10, 2'd0, 5'd27);
        drive(1'b1, 32'd11, 32'd11, 2'd0, 5'd28);
        drive(1'b1, 32'd12, 32'd12, 2'd0, 5'd29);
        drive(1'b1, 32'd13, 32'd13, 2'd0, 5'd30);
        reset = 1'b1;
        @(negedge clk);
        chk_out("rs_before", 32'd100, 5'd27);
        drive(1'b0, 32'd0, 32'd0, 2'd0, 5'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rs_out_valid", 64'(out_valid), 64'd0);
        chk("rs_in_ready", 64'(in_ready), 64'd1);
        chk("rs_out_result", 64'(out_result), 64'd0);
        chk("rs_out_tag", 64'(out_tag), 64'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'd7, 32'd6, 2'd0, 5'd31);
        @(negedge clk);
        chk("rs_new_c0_valid", 64'(out_valid), 64'd0);
        for (int c = 1; c < 3; c++) begin
            drive(1'b0, 32'd0, 32'd0, 2'd0, 5'd0);
            @(negedge clk);
            chk($sformatf("rs_new_c%0d_valid", c), 64'(out_valid), 64'd0);
        end
        drive(1'b0, 32'd0, 32'd0, 2'd0, 5'd0);
        @(negedge clk);
        chk_out("rs_new", 32'h0000002A, 5'd31);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 32'd0, 32'd0, 2'd0, 5'd0);
            @(negedge clk);
            chk($sformatf("rs_tail%0d_valid", c), 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
